// File: rtl/video_mode_selector.sv
// video_mode_selector: two raw front-panel buttons (next/prev) -> committed
// 8-bit video mode code. Each button is synchronised and debounced; rising
// debounced levels step a circular index 0..4, and the index is committed to
// mode_out only after COMMIT_DELAY idle cycles so scrolling through several
// modes produces a single mode_out change.
// Optional auto-repeat on a held button: define VIDEO_MODE_SELECTOR_AUTOREPEAT_EN.

`ifndef MODE_1080p
`define MODE_1080p 8'h01
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h02
`endif
`ifndef MODE_720p
`define MODE_720p 8'h03
`endif
`ifndef MODE_480p
`define MODE_480p 8'h04
`endif
`ifndef MODE_480i
`define MODE_480i 8'h05
`endif

// One button: 2-flop synchroniser plus stability counter. rise pulses in the
// cycle the debounced level is about to go 0->1.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic level,
   output logic rise
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic [CW-1:0] count;

   assign rise = sync2 & ~level & (count == LAST);

   // Two-stage synchroniser for the asynchronous button input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has disagreed with the current one for
   // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level <= 1'b0;
         count <= '0;
      end else if (sync2 == level) begin
         count <= '0;
      end else if (count == LAST) begin
         level <= sync2;
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end
endmodule

module video_mode_selector #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int COMMIT_DELAY    = 50000000,
   parameter int INITIAL_INDEX   = 0,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       button_next,
   input  logic       button_prev,
   output logic [7:0] mode_out,
   output logic [2:0] mode_index,
   output logic       mode_pending
);
   localparam int NUM_BTN = 2;   // bit 0 = next, bit 1 = prev
   localparam int CMW = (COMMIT_DELAY > 1) ? $clog2(COMMIT_DELAY) : 1;
   localparam logic [CMW-1:0] COMMIT_LOAD = CMW'(COMMIT_DELAY - 1);
   localparam logic [2:0] INIT_IDX = 3'(INITIAL_INDEX);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

   function automatic logic [7:0] idx_code(input logic [2:0] idx);
      case (idx)
         3'd0:    idx_code = `MODE_1080p;
         3'd1:    idx_code = `MODE_1080i;
         3'd2:    idx_code = `MODE_720p;
         3'd3:    idx_code = `MODE_480p;
         3'd4:    idx_code = `MODE_480i;
         default: idx_code = `MODE_1080p;
      endcase
   endfunction

   logic [NUM_BTN-1:0] raw, level, rise;
   logic               step_next, step_prev, step_any;
   logic [2:0]         next_index, committed;
   logic [CMW-1:0]     commit_cnt;
   state_t             state;

   assign raw = {button_prev, button_next};

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock  (clock),
         .reset  (reset),
         .button (raw[b]),
         .level  (level[b]),
         .rise   (rise[b])
      );
   end

`ifdef VIDEO_MODE_SELECTOR_AUTOREPEAT_EN
   localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RPW-1:0] REPEAT_LAST = RPW'(REPEAT_CYCLES - 1);

   logic           one_high, repeat_fire;
   logic [RPW-1:0] repeat_cnt;

   assign one_high    = level[0] ^ level[1];
   assign repeat_fire = one_high & (repeat_cnt == REPEAT_LAST);
   assign step_next   = rise[0] | (repeat_fire & level[0]);
   assign step_prev   = rise[1] | (repeat_fire & level[1]);

   // Hold timer: runs only while exactly one button is held, fires every
   // REPEAT_CYCLES after the press step.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         repeat_cnt <= '0;
      else if (!one_high || repeat_fire)
         repeat_cnt <= '0;
      else
         repeat_cnt <= repeat_cnt + 1'b1;
   end
`else
   logic unused_repeat;
   assign unused_repeat = (REPEAT_CYCLES != 0);
   assign step_next     = rise[0];
   assign step_prev     = rise[1];
`endif

   // Opposite steps in the same cycle cancel out entirely.
   assign step_any = step_next ^ step_prev;

   // Circular index arithmetic; out-of-range values recover to 0 on any step.
   always_comb begin
      next_index = mode_index;
      if (step_next && !step_prev) begin
         next_index = (mode_index >= 3'd4) ? 3'd0 : mode_index + 3'd1;
      end else if (step_prev && !step_next) begin
         if (mode_index == 3'd0)
            next_index = 3'd4;
         else if (mode_index > 3'd4)
            next_index = 3'd0;
         else
            next_index = mode_index - 3'd1;
      end
   end

   // Selected (not yet committed) index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         mode_index <= INIT_IDX;
      else
         mode_index <= next_index;
   end

   // Commit FSM: every step restarts the idle timer; when it expires the
   // current index is copied to mode_out, but only if it actually differs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         commit_cnt <= '0;
         committed  <= INIT_IDX;
         mode_out   <= idx_code(INIT_IDX);
      end else begin
         case (state)
            S_IDLE: begin
               if (step_any) begin
                  state      <= S_WAIT;
                  commit_cnt <= COMMIT_LOAD;
               end
            end
            S_WAIT: begin
               if (step_any)
                  commit_cnt <= COMMIT_LOAD;
               else if (commit_cnt == '0)
                  state <= S_COMMIT;
               else
                  commit_cnt <= commit_cnt - 1'b1;
            end
            S_COMMIT: begin
               if (mode_index != committed) begin
                  mode_out  <= idx_code(mode_index);
                  committed <= mode_index;
               end
               // A step landing on the commit cycle starts a fresh delay.
               if (step_any) begin
                  state      <= S_WAIT;
                  commit_cnt <= COMMIT_LOAD;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Registered "selection not yet committed" flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         mode_pending <= 1'b0;
      else
         mode_pending <= (mode_index != committed);
   end
endmodule

// File: tb/tb_video_mode_selector.sv
// Bench for video_mode_selector: a behavioural model (window-based debounce,
// modulo-5 index, commit deadline) checked every cycle, plus directed
// literal expectations for each scenario.

`ifndef MODE_1080p
`define MODE_1080p 8'h01
`endif
`ifndef MODE_1080i
`define MODE_1080i 8'h02
`endif
`ifndef MODE_720p
`define MODE_720p 8'h03
`endif
`ifndef MODE_480p
`define MODE_480p 8'h04
`endif
`ifndef MODE_480i
`define MODE_480i 8'h05
`endif

module tb_video_mode_selector;
   localparam int DB   = 4;
   localparam int CD   = 10;
   localparam int RP   = 8;
   localparam int INIT = 0;
`ifdef VIDEO_MODE_SELECTOR_AUTOREPEAT_EN
   localparam int REL  = 5;
`else
   localparam int REL  = 20;
`endif

   logic       clock = 1'b0;
   logic       reset, button_next, button_prev;
   logic [7:0] mode_out;
   logic [2:0] mode_index;
   logic       mode_pending;

   int         checks = 0;
   int         failures = 0;
   int         changes = 0;
   int         c0;
   logic [7:0] last_mode = 8'h00;

   always #5 clock = ~clock;

   video_mode_selector #(
      .DEBOUNCE_CYCLES (DB),
      .COMMIT_DELAY    (CD),
      .INITIAL_INDEX   (INIT),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .button_next  (button_next),
      .button_prev  (button_prev),
      .mode_out     (mode_out),
      .mode_index   (mode_index),
      .mode_pending (mode_pending)
   );

   function automatic logic [7:0] code_of(input int i);
      case (i)
         0:       code_of = `MODE_1080p;
         1:       code_of = `MODE_1080i;
         2:       code_of = `MODE_720p;
         3:       code_of = `MODE_480p;
         4:       code_of = `MODE_480i;
         default: code_of = 8'h00;
      endcase
   endfunction

   // ---------------- behavioural model ----------------
   logic m_r1 [2];
   logic m_r2 [2];
   logic m_db [2];
   logic m_win [2][DB-1];   // previous DB-1 synchronised samples
   int   m_flip [2];        // edge of last debounced change
   int   m_idx, m_com, m_dl, m_edge, m_hs;
   logic m_pend;

   always @(posedge clock or posedge reset) begin : model
      logic seen, diff, flip, sn, sp;
      logic ndb [2];
      int   ni;
`ifdef VIDEO_MODE_SELECTOR_AUTOREPEAT_EN
      logic one_old, one_new;
`endif
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            m_r1[b]   <= 1'b0;
            m_r2[b]   <= 1'b0;
            m_db[b]   <= 1'b0;
            m_flip[b] <= -DB;
            for (int k = 0; k < DB-1; k++) m_win[b][k] <= 1'b0;
         end
         m_idx  <= INIT;
         m_com  <= INIT;
         m_pend <= 1'b0;
         m_dl   <= -1;
         m_edge <= 0;
         m_hs   <= 0;
      end else begin
         sn = 1'b0;
         sp = 1'b0;
         for (int b = 0; b < 2; b++) begin
            seen = m_r2[b];
            // level accepted once the last DB samples all disagree with it
            diff = (seen != m_db[b]);
            for (int k = 0; k < DB-1; k++)
               if (m_win[b][k] == m_db[b]) diff = 1'b0;
            flip   = diff && (m_edge - m_flip[b] >= DB);
            ndb[b] = flip ? seen : m_db[b];
            if (flip) m_flip[b] <= m_edge;
            if (flip && seen) begin
               if (b == 0) sn = 1'b1;
               else        sp = 1'b1;
            end
            m_db[b]     <= ndb[b];
            m_win[b][0] <= seen;
            for (int k = 1; k < DB-1; k++) m_win[b][k] <= m_win[b][k-1];
            m_r2[b] <= m_r1[b];
         end
         m_r1[0] <= button_next;
         m_r1[1] <= button_prev;
`ifdef VIDEO_MODE_SELECTOR_AUTOREPEAT_EN
         one_old = m_db[0] ^ m_db[1];
         one_new = ndb[0] ^ ndb[1];
         if (one_old && (m_edge > m_hs) && ((m_edge - m_hs) % RP == 0)) begin
            sn = sn | m_db[0];
            sp = sp | m_db[1];
         end
         if (one_new && !one_old) m_hs <= m_edge;
`endif
         ni = m_idx;
         if (sn && !sp)      ni = (m_idx >= 4) ? 0 : m_idx + 1;
         else if (sp && !sn) ni = (m_idx == 0) ? 4 : ((m_idx > 4) ? 0 : m_idx - 1);
         m_idx <= ni;
         if (m_dl == m_edge) m_com <= m_idx;
         if (sn != sp)       m_dl  <= m_edge + CD + 1;
         m_pend <= (m_idx != m_com);
         m_edge <= m_edge + 1;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
      end
   endtask

   // Advance n cycles; at each falling edge compare DUT against the model.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         if (mode_out != last_mode) changes++;
         last_mode = mode_out;
         if (!reset) begin
            chk("cyc_mode_out",   int'(mode_out),     int'(code_of(m_com)));
            chk("cyc_mode_index", int'(mode_index),   m_idx);
            chk("cyc_pending",    int'(mode_pending), int'(m_pend));
         end
      end
   endtask

   task automatic press(input logic n, input logic p, input int hold, input int gap);
      button_next = n;
      button_prev = p;
      tick(hold);
      button_next = 1'b0;
      button_prev = 1'b0;
      tick(gap);
   endtask

   initial begin
      reset = 1'b0;
      button_next = 1'b0;
      button_prev = 1'b0;
      #2 reset = 1'b1;
      tick(3);
      reset = 1'b0;
      last_mode = mode_out;

      // reset state, then idle
      chk("rst_mode_out", int'(mode_out), int'(`MODE_1080p));
      chk("rst_index",    int'(mode_index), 0);
      chk("rst_pending",  int'(mode_pending), 0);
      tick(100);
      chk("idle_mode_out", int'(mode_out), int'(`MODE_1080p));
      chk("idle_index",    int'(mode_index), 0);
      chk("idle_pending",  int'(mode_pending), 0);

      // single next press
      c0 = changes;
      button_next = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick(1);
         if (t == REL) button_next = 1'b0;
         if (t == 5)  chk("press_idx_before", int'(mode_index), 0);
         if (t == 6) begin
            chk("press_idx_step",  int'(mode_index), 1);
            chk("press_pend_lag",  int'(mode_pending), 0);
         end
         if (t == 7)  chk("press_pend_set",   int'(mode_pending), 1);
         if (t == 16) chk("press_out_before", int'(mode_out), int'(`MODE_1080p));
         if (t == 17) chk("press_out_commit", int'(mode_out), int'(`MODE_1080i));
         if (t == 18) chk("press_pend_clr",   int'(mode_pending), 0);
      end
      chk("press_changes", changes - c0, 1);

      // bounce 1,0,1,0 then steady high -> one step
      button_next = 1'b1; tick(1);
      button_next = 1'b0; tick(1);
      button_next = 1'b1; tick(1);
      button_next = 1'b0; tick(1);
      press(1'b1, 1'b0, 5, 30);
      chk("bounce_idx", int'(mode_index), 2);
      chk("bounce_out", int'(mode_out), int'(`MODE_720p));

      // wrap-around
      press(1'b0, 1'b1, 5, 30);
      press(1'b0, 1'b1, 5, 30);
      chk("back_to_0", int'(mode_index), 0);
      press(1'b0, 1'b1, 5, 30);
      chk("wrap_prev_idx", int'(mode_index), 4);
      chk("wrap_prev_out", int'(mode_out), int'(`MODE_480i));
      press(1'b1, 1'b0, 5, 30);
      chk("wrap_next_idx", int'(mode_index), 0);
      chk("wrap_next_out", int'(mode_out), int'(`MODE_1080p));

      // three quick next presses commit once, straight to 480p
      c0 = changes;
      press(1'b1, 1'b0, 5, 5);
      press(1'b1, 1'b0, 5, 5);
      press(1'b1, 1'b0, 5, 30);
      chk("scroll_changes", changes - c0, 1);
      chk("scroll_out", int'(mode_out), int'(`MODE_480p));
      chk("scroll_idx", int'(mode_index), 3);

      // next then prev within the delay: no rewrite
      c0 = changes;
      press(1'b1, 1'b0, 5, 5);
      press(1'b0, 1'b1, 5, 30);
      chk("back_forth_changes", changes - c0, 0);
      chk("back_forth_idx", int'(mode_index), 3);
      chk("back_forth_pend", int'(mode_pending), 0);

      // both buttons together
      press(1'b1, 1'b1, 5, 30);
      chk("both_idx", int'(mode_index), 3);
      chk("both_out", int'(mode_out), int'(`MODE_480p));

      // reset during WAIT
      button_next = 1'b1;
      tick(8);
      chk("wait_pend", int'(mode_pending), 1);
      chk("wait_idx", int'(mode_index), 4);
      reset = 1'b1;
      button_next = 1'b0;
      #1;
      chk("rst_wait_out",  int'(mode_out), int'(`MODE_1080p));
      chk("rst_wait_idx",  int'(mode_index), 0);
      chk("rst_wait_pend", int'(mode_pending), 0);
      tick(2);
      reset = 1'b0;
      tick(30);
      chk("post_rst_out", int'(mode_out), int'(`MODE_1080p));
      chk("post_rst_idx", int'(mode_index), 0);

`ifdef VIDEO_MODE_SELECTOR_AUTOREPEAT_EN
      // held next: steps at 0, 8, 16, 24 cycles of debounced hold
      button_next = 1'b1;
      for (int t = 1; t <= 36; t++) begin
         tick(1);
         if (t == 6)  chk("rep_first", int'(mode_index), 1);
         if (t == 14) chk("rep_second", int'(mode_index), 2);
         if (t == 36) chk("rep_final", int'(mode_index), 4);
      end
      button_next = 1'b0;
      tick(60);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
